// File: rtl/nes_pkg.sv
// nes_pkg: shared types and constants for the NROM cartridge loader
package nes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CHECK,
    S_COPY_PRG,
    S_COPY_CHR,
    S_REPORT,
    S_WAIT_TX,
    S_RUN
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MAGIC,
    ERR_SIZE,
    ERR_MAPPER
  } err_code_t;

  localparam logic [31:0] INES_MAGIC = 32'h4E45_531A;
  localparam logic [7:0]  ASCII_S    = 8'h53;
  localparam logic [7:0]  ASCII_F    = 8'h46;

  // First failing header test wins: magic, then bank counts, then mapper
  function automatic err_code_t check_header(input logic [31:0] magic, input logic [7:0] prg,
                                             input logic [7:0] chr, input logic [7:0] mapper);
    return magic != INES_MAGIC ? ERR_MAGIC :
           ((prg != 8'd1 && prg != 8'd2) || chr != 8'd1) ? ERR_SIZE :
           mapper != 8'd0 ? ERR_MAPPER : ERR_NONE;
  endfunction

endpackage

// File: rtl/loader_copy_engine.sv
// loader_copy_engine: streams a buffer region into ROM at one byte per cycle
module loader_copy_engine #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_len,
  input  logic          i_sel,
  input  logic [7:0]    i_buf_data,
  output logic [AW-1:0] o_buf_addr,
  output logic          o_active,
  output logic          o_we,
  output logic          o_sel,
  output logic [14:0]   o_addr,
  output logic [7:0]    o_data,
  output logic          o_done
);

  logic          r_active;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_len;
  logic          r_sel;
  logic          r_wr_valid;
  logic [14:0]   r_wr_addr;
  logic          r_wr_last;
  logic          w_last;

  assign w_last     = r_cnt == r_len - 1'b1;
  assign o_buf_addr = r_base + r_cnt;
  assign o_active   = r_active;
  assign o_we       = r_wr_valid;
  assign o_sel      = r_wr_valid & r_sel;
  assign o_addr     = r_wr_valid ? r_wr_addr : '0;
  assign o_data     = r_wr_valid ? i_buf_data : '0;
  assign o_done     = r_wr_valid & r_wr_last;

  // Read counter feeds a one-stage write pipeline; a new start may overlap the last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_cnt      <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_sel      <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_last  <= 1'b0;
    end else if (i_abort) begin
      r_active   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_last  <= 1'b0;
    end else begin
      r_wr_valid <= r_active;
      r_wr_addr  <= r_cnt[14:0];
      r_wr_last  <= r_active & w_last;
      if (i_start) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_base   <= i_base;
        r_len    <= i_len;
        r_sel    <= i_sel;
      end else if (r_active) begin
        r_cnt    <= r_cnt + 1'b1;
        r_active <= !w_last;
      end
    end
  end

endmodule

// File: rtl/nrom_loader.sv
// nrom_loader: validates an iNES image in the UART buffer, programs cartridge ROM, releases the CPU
module nrom_loader
  import nes_pkg::*;
#(
  parameter int HDR_LEN        = 16,
  parameter int PRG_BANK_BYTES = 16384,
  parameter int CHR_BYTES      = 8192,
  parameter int BUF_AW         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              image_ready,
  input  logic              stop,
  output logic [BUF_AW-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic              prog_we,
  output logic              prog_sel,
  output logic [14:0]       prog_addr,
  output logic [7:0]        prog_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              rx_clear,
  output logic              cpu_hold,
  output logic              running,
  output logic              prg_mirror,
  output logic [1:0]        err_code,
  output logic              busy
);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [4:0]        r_hdr_cnt;
  logic [4:0]        w_idx;
  logic [31:0]       r_magic;
  logic [7:0]        r_prg_banks;
  logic [7:0]        r_chr_banks;
  logic [7:0]        r_mapper;
  err_code_t         r_err;
  err_code_t         w_err;
  logic [7:0]        r_tx_data;
  logic              r_prg_mirror;
  logic [BUF_AW-1:0] w_prg_size;
  logic [BUF_AW-1:0] w_base;
  logic [BUF_AW-1:0] w_len;
  logic [BUF_AW-1:0] w_eng_addr;
  logic              w_start;
  logic              w_sel;
  logic              w_abort;
  logic              w_active;
  logic              w_we;
  logic              w_done;
  logic              w_tx_ok;

  assign w_idx      = r_hdr_cnt - 5'd1;
  assign w_err      = check_header(r_magic, r_prg_banks, r_chr_banks, r_mapper);
  assign w_prg_size = r_prg_banks == 8'd2 ? BUF_AW'(2 * PRG_BANK_BYTES) : BUF_AW'(PRG_BANK_BYTES);
  assign w_abort    = stop && r_state != S_IDLE;
  assign w_start    = !stop && ((r_state == S_CHECK && w_err == ERR_NONE) || (r_state == S_COPY_PRG && w_done));
  assign w_sel      = r_state != S_CHECK;
  assign w_base     = w_sel ? BUF_AW'(HDR_LEN) + w_prg_size : BUF_AW'(HDR_LEN);
  assign w_len      = w_sel ? BUF_AW'(CHR_BYTES) : w_prg_size;
  assign w_tx_ok    = r_tx_data == ASCII_S;
  assign tx_data    = r_tx_data;
  assign prg_mirror = r_prg_mirror;
  assign err_code   = r_err;

  loader_copy_engine #(.AW(BUF_AW)) u_copy (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_abort    (w_abort),
    .i_base     (w_base),
    .i_len      (w_len),
    .i_sel      (w_sel),
    .i_buf_data (buf_data),
    .o_buf_addr (w_eng_addr),
    .o_active   (w_active),
    .o_we       (w_we),
    .o_sel      (prog_sel),
    .o_addr     (prog_addr),
    .o_data     (prog_data),
    .o_done     (w_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state; stop from any active state wins over every other event
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (image_ready) w_next = S_HDR;
      S_HDR:      if (r_hdr_cnt == 5'(HDR_LEN)) w_next = S_CHECK;
      S_CHECK:    w_next = w_err == ERR_NONE ? S_COPY_PRG : S_REPORT;
      S_COPY_PRG: if (w_done) w_next = S_COPY_CHR;
      S_COPY_CHR: if (w_done) w_next = S_REPORT;
      S_REPORT:   w_next = S_WAIT_TX;
      S_WAIT_TX:  if (tx_done) w_next = w_tx_ok ? S_RUN : S_IDLE;
      default:    w_next = r_state;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Outputs; cpu_hold drops in the same cycle the 'S' transmission completes
  always_comb begin
    busy     = r_state != S_IDLE && r_state != S_RUN;
    running  = r_state == S_RUN;
    tx_start = r_state == S_REPORT;
    rx_clear = w_abort || (r_state == S_WAIT_TX && tx_done && !w_tx_ok);
    cpu_hold = !((r_state == S_RUN && !stop) || (r_state == S_WAIT_TX && tx_done && w_tx_ok && !stop));
    prog_we  = w_we && (r_state == S_COPY_PRG || r_state == S_COPY_CHR);
    buf_addr = r_state == S_HDR ? BUF_AW'(r_hdr_cnt) : w_active ? w_eng_addr : '0;
  end

  // Header fetch: address issued at count n, its byte captured at count n+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_cnt   <= '0;
      r_magic     <= '0;
      r_prg_banks <= '0;
      r_chr_banks <= '0;
      r_mapper    <= '0;
    end else begin
      r_hdr_cnt <= r_state == S_HDR ? r_hdr_cnt + 5'd1 : '0;
      if (r_state == S_HDR && r_hdr_cnt != '0) begin
        if (w_idx < 5'd4)  r_magic       <= {r_magic[23:0], buf_data};
        if (w_idx == 5'd4) r_prg_banks   <= buf_data;
        if (w_idx == 5'd5) r_chr_banks   <= buf_data;
        if (w_idx == 5'd6) r_mapper[3:0] <= buf_data[7:4];
        if (w_idx == 5'd7) r_mapper[7:4] <= buf_data[7:4];
      end
    end
  end

  // Status: error code, PRG mirroring and the character to report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err        <= ERR_NONE;
      r_tx_data    <= '0;
      r_prg_mirror <= 1'b0;
    end else if (r_state == S_IDLE && image_ready) begin
      r_err        <= ERR_NONE;
      r_prg_mirror <= 1'b0;
    end else if (r_state == S_CHECK && !stop) begin
      r_err        <= w_err;
      r_tx_data    <= w_err != ERR_NONE ? ASCII_F : r_tx_data;
      r_prg_mirror <= w_err == ERR_NONE && r_prg_banks == 8'd1;
    end else if (r_state == S_COPY_CHR && w_done && !stop) begin
      r_tx_data <= ASCII_S;
    end
  end

endmodule
